// File: rtl/pwm_core.sv
// Single-channel PWM generator clocked by slowclk ticks, with double-buffered
// period/duty that swap in glitch-free at period boundaries via a load/ack handshake.
module pwm_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             slowclk,
   input  logic             enable,
   input  logic [WIDTH-1:0] period_in,
   input  logic [WIDTH-1:0] duty_in,
   input  logic             load,
   output logic             load_ack,
   output logic             pwm_out,
   output logic             period_end
);

   logic             slow_d;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] period_q;
   logic [WIDTH-1:0] duty_q;
   logic [WIDTH-1:0] pend_period;
   logic [WIDTH-1:0] pend_duty;
   logic             pending;

   logic             tick;
   logic             boundary;
   logic             apply;
   logic [WIDTH-1:0] next_period;
   logic [WIDTH-1:0] next_duty;

   assign tick     = slowclk & ~slow_d;
   assign boundary = tick & enable & (cnt == period_q);

   // A coincident load bypasses the pending registers so its values land this cycle.
   assign apply       = (pending | load) & (boundary | ~enable);
   assign next_period = load ? period_in : pend_period;
   assign next_duty   = load ? duty_in : pend_duty;

   always_ff @(posedge clk) begin
      if (reset) begin
         slow_d <= 1'b0;
         cnt    <= '0;
      end else begin
         slow_d <= slowclk;
         if (!enable) begin
            cnt <= '0;
         end else if (tick) begin
            cnt <= (cnt == period_q) ? '0 : cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         period_q    <= '0;
         duty_q      <= '0;
         pend_period <= '0;
         pend_duty   <= '0;
         pending     <= 1'b0;
         load_ack    <= 1'b0;
      end else begin
         load_ack <= 1'b0;
         if (apply) begin
            period_q <= next_period;
            duty_q   <= next_duty;
            pending  <= 1'b0;
            load_ack <= 1'b1;
         end else if (load) begin
            pend_period <= period_in;
            pend_duty   <= duty_in;
            pending     <= 1'b1;
         end
      end
   end

   // Compare uses the pre-edge cnt/duty_q, so pwm_out trails the counter by one clk.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_out    <= 1'b0;
         period_end <= 1'b0;
      end else begin
         pwm_out    <= enable & (cnt < duty_q);
         period_end <= boundary;
      end
   end

endmodule

// File: tb/tb_pwm_core.sv
// Directed bench for pwm_core: slowclk toggles every 2 clk (one tick per 4 clk),
// PWM high time and period length are measured between period_end pulses.
module tb_pwm_core;

   logic       clk = 1'b0;
   logic       reset;
   logic       slowclk;
   logic       enable;
   logic [7:0] periodIn;
   logic [7:0] dutyIn;
   logic       load;
   logic       loadAck;
   logic       pwmOut;
   logic       periodEnd;

   int checkCount = 0;
   int errorCount = 0;

   pwm_core #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .slowclk    (slowclk),
      .enable     (enable),
      .period_in  (periodIn),
      .duty_in    (dutyIn),
      .load       (load),
      .load_ack   (loadAck),
      .pwm_out    (pwmOut),
      .period_end (periodEnd)
   );

   always #5 clk = ~clk;

   initial begin
      slowclk = 1'b0;
      forever begin
         @(posedge clk);
         @(posedge clk);
         #1 slowclk = ~slowclk;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One-clk load strobe; returns at the negedge after the capturing edge.
   task automatic applyStimulus(input logic [7:0] p, input logic [7:0] d);
      @(posedge clk);
      #1 periodIn = p;
      dutyIn = d;
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      @(negedge clk);
   endtask

   task automatic waitPeriodEnd(output int highs, output int ack);
      highs = 0;
      ack   = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (periodEnd) begin
            ack = int'(loadAck);
            return;
         end
         if (pwmOut) highs++;
      end
      checkOutput("period_end_timeout", 0, 1);
   endtask

   // Starts on a period_end sample, ends on the next one (exclusive).
   task automatic measurePeriod(output int highs, output int len, output int acks);
      highs = 0;
      len   = 0;
      acks  = 0;
      for (int i = 0; i < 200; i++) begin
         if (pwmOut) highs++;
         if (loadAck) acks++;
         len++;
         @(negedge clk);
         if (periodEnd) return;
      end
      checkOutput("measure_timeout", 0, 1);
   endtask

   int highs, len, acks, ack, peCount;

   initial begin
      reset    = 1'b1;
      enable   = 1'b1;
      load     = 1'b0;
      periodIn = 8'd0;
      dutyIn   = 8'd0;

      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 load = ~load;
         enable = ~enable;
         periodIn = 8'(i * 3 + 1);
         dutyIn = 8'(i + 2);
         @(negedge clk);
         checkOutput("reset_load_ack", loadAck, 0);
         checkOutput("reset_pwm_out", pwmOut, 0);
         checkOutput("reset_period_end", periodEnd, 0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      enable = 1'b0;
      load = 1'b0;
      @(negedge clk);
      checkOutput("release_cnt", dut.cnt, 0);

      applyStimulus(8'd9, 8'd3);
      checkOutput("disabled_load_ack", loadAck, 1);
      @(negedge clk);
      checkOutput("ack_one_clk", loadAck, 0);
      @(posedge clk);
      #1 enable = 1'b1;
      waitPeriodEnd(highs, ack);
      measurePeriod(highs, len, acks);
      checkOutput("p9d3_high", highs, 12);
      checkOutput("p9d3_len", len, 40);
      measurePeriod(highs, len, acks);
      checkOutput("p9d3_high2", highs, 12);
      checkOutput("p9d3_len2", len, 40);

      applyStimulus(8'd9, 8'd0);
      checkOutput("d0_pending_no_ack", loadAck, 0);
      waitPeriodEnd(highs, ack);
      checkOutput("d0_ack_at_boundary", ack, 1);
      measurePeriod(highs, len, acks);
      checkOutput("d0_high", highs, 0);
      checkOutput("d0_acks", acks, 1);

      applyStimulus(8'd9, 8'd10);
      checkOutput("d10_pending_no_ack", loadAck, 0);
      waitPeriodEnd(highs, ack);
      checkOutput("d10_ack_at_boundary", ack, 1);
      measurePeriod(highs, len, acks);
      checkOutput("d10_high_first", highs, 39);
      measurePeriod(highs, len, acks);
      checkOutput("d10_high_full", highs, 40);

      applyStimulus(8'd9, 8'd3);
      waitPeriodEnd(highs, ack);
      measurePeriod(highs, len, acks);
      checkOutput("d10_to_d3_high", highs, 13);
      repeat (15) @(posedge clk);
      applyStimulus(8'd9, 8'd7);
      checkOutput("cnt4_load_no_ack", loadAck, 0);
      waitPeriodEnd(highs, ack);
      checkOutput("cnt4_rest_keeps_d3", highs, 0);
      checkOutput("cnt4_ack_with_period_end", ack, 1);
      measurePeriod(highs, len, acks);
      checkOutput("d7_high", highs, 28);
      checkOutput("d7_len", len, 40);

      applyStimulus(8'd9, 8'd5);
      checkOutput("double_load1_no_ack", loadAck, 0);
      applyStimulus(8'd9, 8'd2);
      checkOutput("double_load2_no_ack", loadAck, 0);
      waitPeriodEnd(highs, ack);
      checkOutput("double_load_ack", ack, 1);
      measurePeriod(highs, len, acks);
      checkOutput("double_load_single_ack", acks, 1);
      checkOutput("last_load_wins_high", highs, 8);

      repeat (38) @(posedge clk);
      applyStimulus(8'd9, 8'd6);
      checkOutput("bypass_period_end", periodEnd, 1);
      checkOutput("bypass_ack", loadAck, 1);
      measurePeriod(highs, len, acks);
      checkOutput("bypass_d6_high", highs, 24);
      checkOutput("bypass_d6_len", len, 40);

      applyStimulus(8'd9, 8'd4);
      checkOutput("pre_reset_no_ack", loadAck, 0);
      repeat (22) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checkOutput("cnt_before_reset", dut.cnt, 6);
      @(negedge clk);
      checkOutput("midreset_ack", loadAck, 0);
      checkOutput("midreset_pwm", pwmOut, 0);
      checkOutput("midreset_cnt", dut.cnt, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      acks = 0;
      highs = 0;
      peCount = 0;
      for (int i = 0; i < 108; i++) begin
         @(negedge clk);
         if (loadAck) acks++;
         if (pwmOut) highs++;
         if (i >= 8 && periodEnd) peCount++;
      end
      checkOutput("post_reset_no_ack", acks, 0);
      checkOutput("post_reset_pwm_low", highs, 0);
      checkOutput("period0_every_tick", peCount, 25);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
